// File: rtl/vga_scan_timer_pkg.sv
// Shared timing defaults and grid geometry for the VGA scan timer.
// Default timing is 640x480@60 with 8x8-pixel grid cells.
package vga_scan_timer_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int GRID_CELL_SHIFT = 3;
    localparam int GRID_COLS       = 80;
    localparam int GRID_ROWS       = 60;

    localparam int GX_W = 8;
    localparam int GY_W = 7;

    function automatic int cnt_w(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_scan_timer_axis.sv
// One scan axis: wrapping position counter plus active-region and
// raw sync-window decode. Used for both horizontal and vertical.
module scan_axis_counter
    import vga_scan_timer_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    localparam int TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int W     = cnt_w(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync_raw
);

    logic [W-1:0] r_cnt;

    assign cnt      = r_cnt;
    assign wrap     = en && (r_cnt == W'(TOTAL - 1));
    assign active   = r_cnt < W'(ACTIVE);
    assign sync_raw = (r_cnt >= W'(ACTIVE + FP)) &&
                      (r_cnt <= W'(ACTIVE + FP + SYNC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scan_timer.sv
// Pixel timing for the grid renderer: de/gx/gy at stage 1,
// hsync/vsync at stage 2 to line up with registered RGB, plus frame tick.
module vga_scan_timer
    import vga_scan_timer_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int CELL_SHIFT = GRID_CELL_SHIFT,
    parameter bit SYNC_POL   = 1'b0,
    parameter int N_COLS     = GRID_COLS,
    parameter int N_ROWS     = GRID_ROWS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_en,
    output logic            de,
    output logic [GX_W-1:0] gx,
    output logic [GY_W-1:0] gy,
    output logic            hsync,
    output logic            vsync,
    output logic            frame_tick
);

    localparam int HW = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);

    if (((H_ACTIVE >> CELL_SHIFT) != N_COLS) ||
        ((V_ACTIVE >> CELL_SHIFT) != N_ROWS)) begin : g_bad_grid
        $error("active area does not match grid size");
    end

    logic [HW-1:0]   w_hcnt;
    logic [VW-1:0]   w_vcnt;
    logic            w_h_wrap;
    logic            w_v_wrap;
    logic            w_h_active;
    logic            w_v_active;
    logic            w_hs_raw;
    logic            w_vs_raw;
    logic            w_active;
    logic [GX_W-1:0] w_gx;
    logic [GY_W-1:0] w_gy;
    logic            w_hs_lvl;
    logic            w_vs_lvl;

    logic            r_de;
    logic [GX_W-1:0] r_gx;
    logic [GY_W-1:0] r_gy;
    logic            r_hs1;
    logic            r_hs2;
    logic            r_vs1;
    logic            r_vs2;

    scan_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .en       (pix_en),
        .cnt      (w_hcnt),
        .wrap     (w_h_wrap),
        .active   (w_h_active),
        .sync_raw (w_hs_raw)
    );

    // Vertical axis steps only on the last pixel of each line.
    scan_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .en       (w_h_wrap),
        .cnt      (w_vcnt),
        .wrap     (w_v_wrap),
        .active   (w_v_active),
        .sync_raw (w_vs_raw)
    );

    assign w_active = w_h_active && w_v_active;
    assign w_gx     = w_active ? GX_W'(w_hcnt >> CELL_SHIFT) : '0;
    assign w_gy     = w_active ? GY_W'(w_vcnt >> CELL_SHIFT) : '0;
    assign w_hs_lvl = w_hs_raw ? SYNC_POL : ~SYNC_POL;
    assign w_vs_lvl = w_vs_raw ? SYNC_POL : ~SYNC_POL;

    // Last pixel of the last visible line: blanking starts on this strobe.
    assign frame_tick = w_h_wrap && !w_v_wrap &&
                        (w_vcnt == VW'(V_ACTIVE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de  <= 1'b0;
            r_gx  <= '0;
            r_gy  <= '0;
            r_hs1 <= ~SYNC_POL;
            r_hs2 <= ~SYNC_POL;
            r_vs1 <= ~SYNC_POL;
            r_vs2 <= ~SYNC_POL;
        end else if (pix_en) begin
            r_de  <= w_active;
            r_gx  <= w_gx;
            r_gy  <= w_gy;
            r_hs1 <= w_hs_lvl;
            r_hs2 <= r_hs1;
            r_vs1 <= w_vs_lvl;
            r_vs2 <= r_vs1;
        end
    end

    assign de    = r_de;
    assign gx    = r_gx;
    assign gy    = r_gy;
    assign hsync = r_hs2;
    assign vsync = r_vs2;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Directed bench for vga_scan_timer on a reduced 48x24 raster
// (32x16 visible, 4x2 grid) so several frames fit in a short run.
module tb_vga_scan_timer;

    localparam int HT = 48;
    localparam int VT = 24;
    localparam int FR = HT * VT;

    typedef struct {
        int k;
        int d;
        int x;
        int y;
        int h;
        int v;
    } vec_t;

    localparam int NV = 18;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic       de;
    logic [7:0] gx;
    logic [6:0] gy;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;

    int   total = 0;
    int   bad = 0;
    int   sc = 0;
    int   ticks = 0;
    int   tick_k[4];
    int   hs_low = 0;
    int   hs_low2 = 0;
    int   vs_low = 0;
    vec_t vt[NV];

    always #5 clk = ~clk;

    vga_scan_timer #(
        .H_ACTIVE   (32),
        .H_FP       (4),
        .H_SYNC     (6),
        .H_BP       (6),
        .V_ACTIVE   (16),
        .V_FP       (2),
        .V_SYNC     (2),
        .V_BP       (4),
        .CELL_SHIFT (3),
        .SYNC_POL   (1'b0),
        .N_COLS     (4),
        .N_ROWS     (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .de         (de),
        .gx         (gx),
        .gy         (gy),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int d, input int x,
                           input int y, input int h, input int v);
        chk({tag, ".de"}, int'(de), d);
        chk({tag, ".gx"}, int'(gx), x);
        chk({tag, ".gy"}, int'(gy), y);
        chk({tag, ".hs"}, int'(hsync), h);
        chk({tag, ".vs"}, int'(vsync), v);
    endtask

    // One clk: frame_tick sampled mid-cycle, outputs settle 1ns after the edge.
    task automatic cyc(input logic en);
        pix_en = en;
        @(negedge clk);
        if (frame_tick) begin
            if (ticks < 4) tick_k[ticks] = en ? sc + 1 : -1;
            ticks++;
        end
        @(posedge clk);
        if (en) sc++;
        #1;
        pix_en = 1'b0;
    endtask

    task automatic strobe(input int gap);
        cyc(1'b1);
        repeat (gap) cyc(1'b0);
    endtask

    initial begin
        vt = '{
            '{1,    1, 0, 0, 1, 1},
            '{8,    1, 0, 0, 1, 1},
            '{9,    1, 1, 0, 1, 1},
            '{32,   1, 3, 0, 1, 1},
            '{33,   0, 0, 0, 1, 1},
            '{37,   0, 0, 0, 1, 1},
            '{38,   0, 0, 0, 0, 1},
            '{43,   0, 0, 0, 0, 1},
            '{44,   0, 0, 0, 1, 1},
            '{385,  1, 0, 1, 1, 1},
            '{752,  1, 3, 1, 1, 1},
            '{753,  0, 0, 0, 1, 1},
            '{865,  0, 0, 0, 1, 1},
            '{866,  0, 0, 0, 1, 0},
            '{961,  0, 0, 0, 1, 0},
            '{962,  0, 0, 0, 1, 1},
            '{1153, 1, 0, 0, 1, 1},
            '{2713, 1, 3, 1, 1, 1}
        };
        for (int i = 0; i < 4; i++) tick_k[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 1, 1);
        chk("reset.tick", int'(frame_tick), 0);
        rst = 1'b0;

        for (int k = 1; k <= 3957; k++) begin
            strobe(k <= 200 ? 3 : 0);
            if (k >= 100 && k <= 147 && !hsync) hs_low++;
            if (k >= 1300 && k <= 1347 && !hsync) hs_low2++;
            if (k >= 2 && k <= FR + 1 && !vsync) vs_low++;
            for (int i = 0; i < NV; i++) begin
                if (vt[i].k == k)
                    chk_out($sformatf("k%0d", k), vt[i].d, vt[i].x,
                            vt[i].y, vt[i].h, vt[i].v);
            end
            if (k == 2708) begin
                repeat (50) cyc(1'b0);
                chk_out("freeze", 1, 2, 1, 1, 1);
                chk("freeze.ticks", ticks, 2);
            end
        end

        chk("hs_low_line2", hs_low, 6);
        chk("hs_low_line27", hs_low2, 6);
        chk("vs_low_frame", vs_low, 2 * HT);
        chk("tick_count", ticks, 3);
        chk("tick0_at", tick_k[0], 768);
        chk("tick1_at", tick_k[1], 768 + FR);
        chk("tick2_at", tick_k[2], 768 + 2 * FR);

        chk_out("pre_rst", 1, 2, 1, 1, 1);
        rst = 1'b1;
        #1;
        chk_out("rst_now", 0, 0, 0, 1, 1);
        chk("rst_now.tick", int'(frame_tick), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        sc = 0;
        ticks = 0;
        for (int i = 0; i < 4; i++) tick_k[i] = 0;

        strobe(0);
        chk_out("rst_first", 1, 0, 0, 1, 1);
        for (int k = 2; k <= 800; k++) strobe(0);
        chk("rst_tick_count", ticks, 1);
        chk("rst_tick_at", tick_k[0], 16 * HT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 want 1");
        $fatal(1, "timeout");
    end

endmodule
